// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: FSM states, bit timing
// derivation and the legal data-width range.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef struct packed {
        int cycle;
        int mid;
    } bit_timing_t;

    // cycle is clocks per bit; mid is the centre count, sampled together with its neighbours
    function automatic bit_timing_t calc_bit_timing(input int clk_fre, input int baud_rate);
        bit_timing_t t;
        t.cycle = (clk_fre * 1000000) / baud_rate;
        t.mid   = t.cycle / 2 - 1;
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side stream interface of the parametrised UART receiver:
// data/valid/ready handshake plus per-frame error flags and status.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_data_ready;
    logic                 rx_err_clr;
    logic                 rx_data_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    logic                 rx_busy;

    modport master (
        input  rx_data_ready,
        input  rx_err_clr,
        output rx_data_valid,
        output rx_data,
        output rx_frame_err,
        output rx_parity_err,
        output rx_overrun,
        output rx_busy
    );

    modport slave (
        output rx_data_ready,
        output rx_err_clr,
        input  rx_data_valid,
        input  rx_data,
        input  rx_frame_err,
        input  rx_parity_err,
        input  rx_overrun,
        input  rx_busy
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit counter 0..CYCLE-1 with strobes at MID-1, MID, MID+1 and end of bit.
// Shared between the UART receiver and transmitter.
module uart_bit_timer #(
    parameter int CYCLE = 434,
    parameter int MID   = 216
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sample_early,
    output logic sample_mid,
    output logic sample_late,
    output logic bit_end
);
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;

    assign sample_early = (cnt_reg == 16'(MID - 1));
    assign sample_mid   = (cnt_reg == 16'(MID));
    assign sample_late  = (cnt_reg == 16'(MID + 1));
    assign bit_end      = (cnt_reg == 16'(CYCLE - 1));

    always_comb begin
        cnt_next = cnt_reg + 16'd1;
        if (clear || bit_end) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting and a one-entry
// output register. Optional parity bit enabled by macro UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_pin,
    uart_rx_param_if.master rx_if
);
    localparam bit_timing_t TIMING    = calc_bit_timing(CLK_FRE, BAUD_RATE);
    localparam int          CYCLE     = TIMING.cycle;
    localparam int          MID       = TIMING.mid;
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic        PAR_SENSE = 1'(PARITY_ODD);

    // Synchroniser and edge history start high so reset never looks like a start bit
    logic rx_meta_reg;
    logic rx_sync_reg;
    logic rx_prev_reg;
    logic fall_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx_pin;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign fall_edge = rx_prev_reg & ~rx_sync_reg;

    uart_state_e state_reg;
    uart_state_e state_next;

    logic sample_early;
    logic sample_mid;
    logic sample_late;
    logic bit_end;

    uart_bit_timer #(
        .CYCLE (CYCLE),
        .MID   (MID)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_reg == ST_IDLE),
        .sample_early (sample_early),
        .sample_mid   (sample_mid),
        .sample_late  (sample_late),
        .bit_end      (bit_end)
    );

    // The third vote input is the live synchronised line at MID+1
    logic samp_early_reg;
    logic samp_mid_reg;
    logic vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_early_reg <= 1'b1;
            samp_mid_reg   <= 1'b1;
        end else begin
            if (sample_early) samp_early_reg <= rx_sync_reg;
            if (sample_mid)   samp_mid_reg   <= rx_sync_reg;
        end
    end

    assign vote = (samp_early_reg & samp_mid_reg) |
                  (samp_early_reg & rx_sync_reg)  |
                  (samp_mid_reg   & rx_sync_reg);

    logic [3:0] bit_cnt_reg;
    logic       stop_cnt_reg;
    logic       last_stop;

    assign last_stop = (stop_cnt_reg == LAST_STOP);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) state_next = ST_START;
            end
            ST_START: begin
                if (sample_late && vote) state_next = ST_IDLE;
                else if (bit_end)        state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Leave at the last vote rather than end of bit to catch back-to-back frames
                if (sample_late && last_stop) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg != ST_DATA) bit_cnt_reg <= '0;
            else if (bit_end)         bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (state_reg != ST_STOP) stop_cnt_reg <= 1'b0;
            else if (bit_end)         stop_cnt_reg <= ~stop_cnt_reg;
        end
    end

    logic                 bit_store;
    logic [DATA_BITS-1:0] bit_sel;
    logic [DATA_BITS-1:0] data_reg;

    assign bit_store = (state_reg == ST_DATA) && sample_late;

    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
            assign bit_sel[gi] = bit_store && (bit_cnt_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
        end else begin
            for (int i = 0; i < DATA_BITS; i++) begin
                if (bit_sel[i]) data_reg[i] <= vote;
            end
        end
    end

    logic ferr_reg;
    logic deliver_reg;
    logic perr_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_reg    <= 1'b0;
            deliver_reg <= 1'b0;
        end else begin
            if (state_reg == ST_STOP && sample_late && !stop_cnt_reg) ferr_reg <= ~vote;
            deliver_reg <= (state_reg == ST_STOP) && sample_late && last_stop;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_reg <= 1'b0;
        end else if (state_reg == ST_PARITY && sample_late) begin
            par_bit_reg <= vote;
        end
    end

    assign perr_frame = ((^data_reg) ^ par_bit_reg) != PAR_SENSE;
`else
    // PARITY_ODD has no effect without a parity bit
    assign perr_frame = PAR_SENSE & 1'b0;
`endif

    // One-entry holding register; a new frame is dropped only if the old one is not leaving
    logic                 valid_reg;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 ferr_out_reg;
    logic                 perr_out_reg;
    logic                 overrun_reg;
    logic                 transfer;

    assign transfer = valid_reg && rx_if.rx_data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            data_out_reg <= '0;
            ferr_out_reg <= 1'b0;
            perr_out_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (deliver_reg && (!valid_reg || transfer)) begin
                valid_reg    <= 1'b1;
                data_out_reg <= data_reg;
                ferr_out_reg <= ferr_reg;
                perr_out_reg <= perr_frame;
            end else if (transfer) begin
                valid_reg <= 1'b0;
            end
            if (deliver_reg && valid_reg && !transfer) overrun_reg <= 1'b1;
            else if (rx_if.rx_err_clr)                 overrun_reg <= 1'b0;
        end
    end

    assign rx_if.rx_data_valid = valid_reg;
    assign rx_if.rx_data       = data_out_reg;
    assign rx_if.rx_frame_err  = ferr_out_reg;
    assign rx_if.rx_parity_err = perr_out_reg;
    assign rx_if.rx_overrun    = overrun_reg;
    assign rx_if.rx_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 50 MHz / 115200 baud (434 clocks per bit).
// With UART_RX_PARITY_EN defined it runs 7-bit frames with even parity.
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
    localparam int DB = 7;
`else
    localparam int DB = 8;
`endif
    localparam int CYCLE = 434;

    logic clk = 1'b0;
    logic rst;
    logic rx_pin;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;
    logic seen;

    always #10 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_param #(
        .CLK_FRE    (50),
        .BAUD_RATE  (115200),
        .DATA_BITS  (DB),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_pin (rx_pin),
        .rx_if  (rx_if)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_d(input logic [8:0] v);
        logic [8:0] m;
        m = 9'((1 << DB) - 1);
        return 16'(v & m);
    endfunction

    task automatic send_bit(input logic b);
        rx_pin = b;
        repeat (CYCLE) @(negedge clk);
    endtask

    // Start bit, data LSB first and, when enabled, the even-parity bit (optionally inverted)
    task automatic send_head(input logic [8:0] d, input logic par_flip);
        logic [8:0] m;
        m = d & 9'((1 << DB) - 1);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(m[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^m) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored without parity bit");
`endif
    endtask

    task automatic pulse_ready();
        rx_if.rx_data_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_data_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [8:0] d, input logic ferr, input logic perr);
        $display("txn %s: valid=%0b data=%0h ferr=%0b perr=%0b", tag, rx_if.rx_data_valid,
                 rx_if.rx_data, rx_if.rx_frame_err, rx_if.rx_parity_err);
        check({tag, "_valid"}, 16'(rx_if.rx_data_valid), 16'd1);
        check({tag, "_data"},  16'(rx_if.rx_data),       exp_d(d));
        check({tag, "_ferr"},  16'(rx_if.rx_frame_err),  16'(ferr));
        check({tag, "_perr"},  16'(rx_if.rx_parity_err), 16'(perr));
    endtask

    initial begin
        rst                 = 1'b1;
        rx_pin              = 1'b1;
        rx_if.rx_data_ready = 1'b0;
        rx_if.rx_err_clr    = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid",   16'(rx_if.rx_data_valid), 16'd0);
        check("rst_data",    16'(rx_if.rx_data),       16'd0);
        check("rst_ferr",    16'(rx_if.rx_frame_err),  16'd0);
        check("rst_perr",    16'(rx_if.rx_parity_err), 16'd0);
        check("rst_overrun", 16'(rx_if.rx_overrun),    16'd0);
        check("rst_busy",    16'(rx_if.rx_busy),       16'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xA5 with ready held: start edge seen 3 clocks after the pin, stop vote at
        // count 217 of bit 9, valid one clock later -> 222 clocks into the stop bit
        rx_if.rx_data_ready = 1'b1;
        send_head(9'h0A5, 1'b0);
        rx_pin = 1'b1;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = rx_if.rx_data_valid;
        end
        check("a5_latency", 16'(cyc), 16'd222);
        check_frame("a5", 9'h0A5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("a5_pulse_end", 16'(rx_if.rx_data_valid), 16'd0);
        @(negedge clk);
        repeat (CYCLE) @(negedge clk);
        rx_if.rx_data_ready = 1'b0;

        // Back-to-back frames with consumer stalled: second frame dropped
        send_head(9'h03C, 1'b0);
        send_bit(1'b1);
        send_head(9'h0C3, 1'b0);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        check_frame("b2b", 9'h03C, 1'b0, 1'b0);
        check("b2b_overrun", 16'(rx_if.rx_overrun), 16'd1);
        pulse_ready();
        check("b2b_drain_valid",  16'(rx_if.rx_data_valid), 16'd0);
        check("b2b_sticky_ovr",   16'(rx_if.rx_overrun),    16'd1);
        rx_if.rx_err_clr = 1'b1;
        @(negedge clk);
        rx_if.rx_err_clr = 1'b0;
        check("b2b_clr_overrun",  16'(rx_if.rx_overrun),    16'd0);
        check("b2b_clr_valid",    16'(rx_if.rx_data_valid), 16'd0);

        // 100-clock low glitch rejected by the start-bit vote
        rx_pin = 1'b0;
        repeat (100) @(negedge clk);
        check("glitch_busy", 16'(rx_if.rx_busy), 16'd1);
        rx_pin = 1'b1;
        repeat (CYCLE) @(negedge clk);
        check("glitch_idle",  16'(rx_if.rx_busy),       16'd0);
        check("glitch_valid", 16'(rx_if.rx_data_valid), 16'd0);

        // Low stop bit flags a framing error; following good frame is clean
        send_head(9'h055, 1'b0);
        send_bit(1'b0);
        rx_pin = 1'b1;
        repeat (20) @(negedge clk);
        check_frame("ferr55", 9'h055, 1'b1, 1'b0);
        pulse_ready();
        send_head(9'h001, 1'b0);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        check_frame("ok01", 9'h001, 1'b0, 1'b0);
        pulse_ready();
        check("ok01_drain", 16'(rx_if.rx_data_valid), 16'd0);

        // Reset in the middle of data bit 4 of 0xFF aborts the frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_pin = 1'b1;
        repeat (CYCLE / 2) @(negedge clk);
        check("rstmid_busy", 16'(rx_if.rx_busy), 16'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rstmid_abort", 16'(rx_if.rx_busy), 16'd0);
        repeat (5 * CYCLE) @(negedge clk);
        check("rstmid_novalid", 16'(rx_if.rx_data_valid), 16'd0);
        check("rstmid_nobusy",  16'(rx_if.rx_busy),       16'd0);
        send_head(9'h012, 1'b0);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        check_frame("after_rst12", 9'h012, 1'b0, 1'b0);
        pulse_ready();

`ifdef UART_RX_PARITY_EN
        // 0x41 has two ones: even parity bit 0 is correct, 1 is an error
        send_head(9'h041, 1'b0);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        check_frame("par_ok", 9'h041, 1'b0, 1'b0);
        pulse_ready();
        send_head(9'h041, 1'b1);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        check_frame("par_bad", 9'h041, 1'b0, 1'b1);
        pulse_ready();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
